pattern_sequencer: RTL and testbench

//   Schedules the three NTSC test-pattern generators onto the single rgb output.

---
 rtl/pattern_sequencer.sv | 106 ++++++++++
 tb/tb_pattern_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
// Frame-synchronous scheduler for the three test-pattern generators.
// Selects composite or single source, advancing on step or auto timer.
module pattern_sequencer #(
  parameter int FRAMES_PER_MODE = 120,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic       active_video,
  input  logic [7:0] rgb0,
  input  logic [7:0] rgb1,
  input  logic [7:0] rgb2,
  input  logic       auto_en,
  input  logic       step,
  output logic [7:0] rgb,
  output logic [1:0] mode,
  output logic       frame_tick
);

  typedef enum logic [1:0] {
    M_COMP = 2'd0,
    M_FONT = 2'd1,
    M_PAL  = 2'd2,
    M_BARS = 2'd3
  } mode_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(FRAMES_PER_MODE - 1);

  mode_t            mode_q;
  logic [CNT_W-1:0] cnt;
  logic             step_pending;
  logic             xy_zero_d;
  logic             xy_zero;
  logic             fs;
  logic             adv_auto;
  logic             advance;
  logic [7:0]       sel;

  assign xy_zero  = (x == 10'd0) && (y == 9'd0);
  assign fs       = xy_zero & ~xy_zero_d;
  assign adv_auto = auto_en && (cnt == CNT_LAST);
  assign advance  = fs && (step_pending || step || adv_auto);
  assign mode     = mode_q;

  // Source mux for the current mode; composite wraps modulo 256
  always_comb begin
    sel = 8'h00;
    unique case (mode_q)
      M_COMP: sel = rgb0 + rgb1 + rgb2;
      M_FONT: sel = rgb0;
      M_PAL:  sel = rgb1;
      M_BARS: sel = rgb2;
    endcase
  end

  // Origin edge detect; starts at 1 so reset never fakes a frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xy_zero_d  <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      xy_zero_d  <= xy_zero;
      frame_tick <= fs;
    end
  end

  // Collapse any number of steps into one advance at the next frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      step_pending <= 1'b0;
    else if (fs)
      step_pending <= 1'b0;
    else if (step)
      step_pending <= 1'b1;
  end

  // Frames spent in the current mode; held at zero while auto is off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (!auto_en || advance)
      cnt <= '0;
    else if (fs)
      cnt <= cnt + 1'b1;
  end

  // Mode steps 0->1->2->3->0, only ever on a frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mode_q <= M_COMP;
    else if (advance)
      mode_q <= mode_t'(2'(mode_q + 2'd1));
  end

  // Registered pixel output, blanked outside the visible area
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rgb <= 8'h00;
    else
      rgb <= active_video ? sel : 8'h00;
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: frame-level reference model,
// per-cycle scoreboard and directed literal checks.
module tb_pattern_sequencer;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int FL  = W * H;
  localparam int FPM = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] x = '0;
  logic [8:0] y = '0;
  logic       active_video = 1'b0;
  logic [7:0] rgb0 = '0;
  logic [7:0] rgb1 = '0;
  logic [7:0] rgb2 = '0;
  logic       auto_en = 1'b0;
  logic       step = 1'b0;
  logic [7:0] rgb;
  logic [1:0] mode;
  logic       frame_tick;

  int pos = 0;
  int n_tests = 0;
  int n_fail = 0;
  bit run_cmp = 1'b0;

  // model state: frame-level view
  int   m_mode = 0;
  int   m_frames = 0;
  bit   m_req = 1'b0;
  bit   m_was_origin = 1'b1;
  logic [7:0] e_rgb = '0;
  bit   e_tick = 1'b0;

  pattern_sequencer #(
    .FRAMES_PER_MODE(FPM),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .x(x),
    .y(y),
    .active_video(active_video),
    .rgb0(rgb0),
    .rgb1(rgb1),
    .rgb2(rgb2),
    .auto_en(auto_en),
    .step(step),
    .rgb(rgb),
    .mode(mode),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] src [4];
    bit origin;
    bit start;
    bit go;
    if (!rst_n) begin
      m_mode = 0;
      m_frames = 0;
      m_req = 1'b0;
      m_was_origin = 1'b1;
      e_rgb = '0;
      e_tick = 1'b0;
    end else begin
      src[0] = rgb0 + rgb1 + rgb2;
      src[1] = rgb0;
      src[2] = rgb1;
      src[3] = rgb2;
      e_rgb = active_video ? src[m_mode] : 8'h00;
      origin = (x == 0) && (y == 0);
      start = origin && !m_was_origin;
      m_was_origin = origin;
      e_tick = start;
      if (start) begin
        go = m_req || step ||
             (auto_en && (m_frames + 1 == FPM));
        if (go) begin
          m_mode = (m_mode + 1) % 4;
          m_frames = 0;
        end else begin
          m_frames = m_frames + 1;
        end
        m_req = 1'b0;
      end else if (step) begin
        m_req = 1'b1;
      end
      if (!auto_en) m_frames = 0;
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      n_tests++;
      if (rgb !== e_rgb || mode !== 2'(m_mode) ||
          frame_tick !== e_tick) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: rgb=%h mode=%0d tick=%b want rgb=%h mode=%0d tick=%b",
                 $time, rgb, mode, frame_tick,
                 e_rgb, m_mode, e_tick);
      end
    end
  end

  task automatic check(input string nm,
                       input int act,
                       input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    pos = (pos + 1) % FL;
    x = 10'(pos % W);
    y = 9'(pos / W);
  endtask

  task automatic to_fs();
    while (pos != 0) cycle();
    cycle();
  endtask

  task automatic pulse_step();
    step = 1'b1;
    cycle();
    step = 1'b0;
  endtask

  task automatic step_at_fs();
    while (pos != 0) cycle();
    step = 1'b1;
    cycle();
    step = 1'b0;
  endtask

  initial begin
    rgb0 = 8'h40;
    rgb1 = 8'h30;
    rgb2 = 8'hE0;
    active_video = 1'b1;
    #2 rst_n = 1'b0;
    run_cmp = 1'b1;
    #1;
    check("rst_rgb", rgb, 0);
    check("rst_mode", mode, 0);
    check("rst_tick", frame_tick, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    cycle();
    check("sum_wrap", rgb, 'h50);
    check("mode0", mode, 0);

    pulse_step();
    cycle();
    pulse_step();
    repeat (3) cycle();
    pulse_step();
    check("step_hold", mode, 0);
    to_fs();
    check("step_adv", mode, 1);
    cycle();
    check("font_rgb", rgb, 'h40);
    repeat (FL) cycle();
    check("step_once", mode, 1);

    pulse_step();
    to_fs();
    pulse_step();
    to_fs();
    step_at_fs();
    check("step_on_fs", mode, 0);

    auto_en = 1'b1;
    for (int f = 1; f <= 13; f++) begin
      to_fs();
      check($sformatf("auto_f%0d", f), mode, (f / 3) % 4);
    end

    to_fs();
    check("coinc_pre", mode, 0);
    pulse_step();
    to_fs();
    check("coinc_single", mode, 1);
    to_fs();
    to_fs();
    check("coinc_hold", mode, 1);
    to_fs();
    check("coinc_restart", mode, 2);

    auto_en = 1'b0;
    active_video = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rgb0 = 8'($urandom_range(255, 1));
      rgb1 = 8'($urandom_range(255, 1));
      rgb2 = 8'($urandom_range(255, 1));
      pulse_step();
      to_fs();
      cycle();
      check($sformatf("blank_m%0d", mode), rgb, 0);
    end

    active_video = 1'b1;
    check("pre_rst_mode", mode, 2);
    pulse_step();
    repeat (3) cycle();
    rst_n = 1'b0;
    #1;
    check("mid_rst_rgb", rgb, 0);
    check("mid_rst_mode", mode, 0);
    check("mid_rst_tick", frame_tick, 0);
    repeat (3) cycle();
    rst_n = 1'b1;
    to_fs();
    check("no_adv_post_rst", mode, 0);

    auto_en = 1'b1;
    for (int i = 0; i < 8000; i++) begin
      active_video = ($urandom % 8) != 0;
      rgb0 = 8'($urandom);
      rgb1 = 8'($urandom);
      rgb2 = 8'($urandom);
      step = ($urandom % 37) == 0;
      if ($urandom % 400 == 0) auto_en = ~auto_en;
      if ($urandom % 2000 == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      cycle();
    end
    step = 1'b0;
    rst_n = 1'b1;
    cycle();

    run_cmp = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
